// File: rtl/convergecast_tree_if.sv
// Report-gathering bus between the reporting array and the convergecast tree.
// The array side (master) drives the per-node reports; the tree (slave)
// returns the root result.
interface convergecast_tree_if #(
   parameter int VALUE_WIDTH = 16,
   parameter int NODES       = 11
);
   localparam int INDEX_WIDTH = (NODES > 1) ? $clog2(NODES) : 1;

   logic                   in_valid;
   logic                   clear;
   logic [NODES-1:0]       present;
   logic [VALUE_WIDTH-1:0] values [NODES];

   logic                   out_valid;
   logic                   out_present;
   logic [VALUE_WIDTH-1:0] out_value;
   logic [INDEX_WIDTH-1:0] out_index;

   modport master (
      output in_valid, clear, present, values,
      input  out_valid, out_present, out_value, out_index
   );

   modport slave (
      input  in_valid, clear, present, values,
      output out_valid, out_present, out_value, out_index
   );
endinterface

// File: rtl/convergecast_tree.sv
// Pipelined MAX_FANOUT-ary min-reduction tree. Every node offers a report
// (present flag + value); the root returns the present report with the
// smallest value, lower node index winning ties. One register stage per
// level; the valid bit travels alongside the data.
module convergecast_tree #(
   parameter int VALUE_WIDTH = 16,
   parameter int MAX_FANOUT  = 5,
   parameter int NODES       = 11
) (
   input  logic                clk,
   input  logic                rst_n,
   convergecast_tree_if.slave  bus
);
   localparam int INDEX_WIDTH = (NODES > 1) ? $clog2(NODES) : 1;

   // Smallest L >= 1 with MAX_FANOUT**L >= NODES.
   function automatic int calc_levels();
      int     l;
      longint p;
      l = 1;
      p = longint'(MAX_FANOUT);
      while (p < longint'(NODES)) begin
         p = p * longint'(MAX_FANOUT);
         l = l + 1;
      end
      return l;
   endfunction

   // Entry count held by stage k; level_cnt(-1) is the raw node count.
   function automatic int level_cnt(int k);
      int c;
      c = NODES;
      for (int i = 0; i <= k; i++) begin
         c = (c + MAX_FANOUT - 1) / MAX_FANOUT;
      end
      return c;
   endfunction

   localparam int LEVELS = calc_levels();

   for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      localparam int NIN  = level_cnt(k - 1);
      localparam int NOUT = level_cnt(k);

      logic                   in_vld;
      logic [NIN-1:0]         in_pres;
      logic [VALUE_WIDTH-1:0] in_val [NIN];
      logic [INDEX_WIDTH-1:0] in_idx [NIN];

      logic                   vld_q, vld_d;
      logic [NOUT-1:0]        pres_q, pres_d;
      logic [VALUE_WIDTH-1:0] val_q [NOUT];
      logic [VALUE_WIDTH-1:0] val_d [NOUT];
      logic [INDEX_WIDTH-1:0] idx_q [NOUT];
      logic [INDEX_WIDTH-1:0] idx_d [NOUT];

      if (k == 0) begin : g_src
         // Stage 0 reads the raw reports; each carries its own node index.
         always_comb begin
            in_vld  = bus.in_valid;
            in_pres = bus.present;
            for (int i = 0; i < NIN; i++) begin
               in_val[i] = bus.values[i];
               in_idx[i] = INDEX_WIDTH'(i);
            end
         end
      end else begin : g_chain
         // Later stages read the previous stage registers.
         always_comb begin
            in_vld  = g_lvl[k-1].vld_q;
            in_pres = g_lvl[k-1].pres_q;
            for (int i = 0; i < NIN; i++) begin
               in_val[i] = g_lvl[k-1].val_q[i];
               in_idx[i] = g_lvl[k-1].idx_q[i];
            end
         end
      end

      // Merge each group of up to MAX_FANOUT children; missing or absent
      // children never win, and bubbles collapse to an all-zero entry.
      always_comb begin
         vld_d  = in_vld;
         pres_d = '0;
         for (int g = 0; g < NOUT; g++) begin
            val_d[g] = '0;
            idx_d[g] = '0;
            for (int c = 0; c < MAX_FANOUT; c++) begin
               if (g * MAX_FANOUT + c < NIN) begin
                  if (in_pres[g*MAX_FANOUT+c] &&
                      (!pres_d[g] ||
                       (in_val[g*MAX_FANOUT+c] < val_d[g]) ||
                       ((in_val[g*MAX_FANOUT+c] == val_d[g]) &&
                        (in_idx[g*MAX_FANOUT+c] < idx_d[g])))) begin
                     pres_d[g] = 1'b1;
                     val_d[g]  = in_val[g*MAX_FANOUT+c];
                     idx_d[g]  = in_idx[g*MAX_FANOUT+c];
                  end
               end
            end
            if (!in_vld) begin
               pres_d[g] = 1'b0;
               val_d[g]  = '0;
               idx_d[g]  = '0;
            end
         end
      end

      // Stage register; clear flushes the stage including this cycle's input.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q  <= 1'b0;
            pres_q <= '0;
            for (int g = 0; g < NOUT; g++) begin
               val_q[g] <= '0;
               idx_q[g] <= '0;
            end
         end else if (bus.clear) begin
            vld_q  <= 1'b0;
            pres_q <= '0;
            for (int g = 0; g < NOUT; g++) begin
               val_q[g] <= '0;
               idx_q[g] <= '0;
            end
         end else begin
            vld_q  <= vld_d;
            pres_q <= pres_d;
            for (int g = 0; g < NOUT; g++) begin
               val_q[g] <= val_d[g];
               idx_q[g] <= idx_d[g];
            end
         end
      end
   end

   assign bus.out_valid   = g_lvl[LEVELS-1].vld_q;
   assign bus.out_present = g_lvl[LEVELS-1].pres_q[0];
   assign bus.out_value   = g_lvl[LEVELS-1].val_q[0];
   assign bus.out_index   = g_lvl[LEVELS-1].idx_q[0];

endmodule

// File: tb/tb_convergecast_tree.sv
// Bench for convergecast_tree: eleven configurations share one stimulus
// stream. Each has a flat min-scan model with a due-cycle queue, compared
// every cycle; configuration 0 (11 nodes, fanout 5) also gets directed
// literal checks.
module tb_convergecast_tree;
   localparam int VW   = 16;
   localparam int MAXN = 26;
   localparam int NCFG = 11;
   localparam int CFG_N [NCFG] = '{11, 1, 1, 5, 5, 6, 6, 25, 25, 26, 26};
   localparam int CFG_F [NCFG] = '{ 5, 2, 5, 2, 5, 2, 5,  2,  5,  2,  5};

   typedef struct packed {
      logic          p;
      logic [VW-1:0] v;
      int            idx;
   } res_t;

   typedef struct {
      int   due;
      res_t r;
   } ent_t;

   function automatic int tb_levels(int n, int f);
      int l;
      int p;
      l = 1;
      p = f;
      while (p < n) begin
         p = p * f;
         l = l + 1;
      end
      return l;
   endfunction

   // Plain scan in node order: first strictly smaller present value wins.
   function automatic res_t ref_min(int n, logic [MAXN-1:0] p, logic [VW-1:0] v [MAXN]);
      res_t r;
      r = '0;
      for (int i = 0; i < n; i++) begin
         if (p[i] && (!r.p || v[i] < r.v)) begin
            r.p   = 1'b1;
            r.v   = v[i];
            r.idx = i;
         end
      end
      return r;
   endfunction

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            clear;
   logic [MAXN-1:0] pres_all;
   logic [VW-1:0]   vals_all [MAXN];
   bit              started = 1'b0;
   int              pass_cnt = 0;
   int              total_cnt = 0;

   always #5 clk = ~clk;

   for (genvar ci = 0; ci < NCFG; ci++) begin : g_cfg
      localparam int N  = CFG_N[ci];
      localparam int F  = CFG_F[ci];
      localparam int L  = tb_levels(N, F);
      localparam int IW = (N > 1) ? $clog2(N) : 1;

      convergecast_tree_if #(.VALUE_WIDTH(VW), .NODES(N)) bus ();

      convergecast_tree #(.VALUE_WIDTH(VW), .MAX_FANOUT(F), .NODES(N)) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );

      always_comb begin
         bus.in_valid = in_valid;
         bus.clear    = clear;
         bus.present  = pres_all[N-1:0];
         for (int i = 0; i < N; i++) bus.values[i] = vals_all[i];
      end

      ent_t q [$];
      int   ecnt = 0;

      // Model: a set accepted at edge e is due right after edge e+L-1.
      always @(posedge clk or negedge rst_n) begin
         ent_t e;
         if (!rst_n) begin
            q.delete();
         end else begin
            ecnt = ecnt + 1;
            if (clear) begin
               q.delete();
            end else if (in_valid) begin
               e.due = ecnt + L - 1;
               e.r   = ref_min(N, pres_all, vals_all);
               q.push_back(e);
            end
         end
      end

      always @(negedge clk) begin
         res_t ex;
         logic ev;
         if (started) begin
            ev = 1'b0;
            ex = '0;
            if (rst_n && q.size() > 0 && q[0].due == ecnt) begin
               ev = 1'b1;
               ex = q[0].r;
               void'(q.pop_front());
            end
            total_cnt = total_cnt + 1;
            if ({bus.out_valid, bus.out_present, bus.out_value, bus.out_index} ===
                {ev, ex.p, ex.v, IW'(ex.idx)}) begin
               pass_cnt = pass_cnt + 1;
            end else begin
               $display("FAIL model N=%0d F=%0d edge=%0d: got v=%0b p=%0b val=%0d idx=%0d, want v=%0b p=%0b val=%0d idx=%0d",
                        N, F, ecnt, bus.out_valid, bus.out_present, bus.out_value, bus.out_index,
                        ev, ex.p, ex.v, IW'(ex.idx));
            end
         end
      end
   end

   task automatic chk(string name, int got, int exp);
      total_cnt = total_cnt + 1;
      if (got == exp) pass_cnt = pass_cnt + 1;
      else $display("FAIL %s: got %0d, want %0d", name, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      clear    = 1'b0;
      pres_all = '0;
      for (int i = 0; i < MAXN; i++) vals_all[i] = '0;
   endtask

   // All nodes present at value base, one winner at index w with value wv.
   task automatic set_winner(int w, int base, int wv);
      in_valid = 1'b1;
      clear    = 1'b0;
      pres_all = '1;
      for (int i = 0; i < MAXN; i++) vals_all[i] = VW'(base);
      vals_all[w] = VW'(wv);
   endtask

   task automatic chk_out(string name, int v, int p, int val, int idx);
      chk({name, ".valid"},   int'(g_cfg[0].bus.out_valid),   v);
      chk({name, ".present"}, int'(g_cfg[0].bus.out_present), p);
      chk({name, ".value"},   int'(g_cfg[0].bus.out_value),   val);
      chk({name, ".index"},   int'(g_cfg[0].bus.out_index),   idx);
   endtask

   initial begin
      int win [4];
      win = '{0, 5, 10, 2};
      rst_n = 1'b1;
      idle();
      #1 rst_n = 1'b0;
      started = 1'b1;
      #1;
      chk_out("reset", 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // Single winner: values[i] = 100-i, all present.
      in_valid = 1'b1;
      pres_all = '1;
      for (int i = 0; i < MAXN; i++) vals_all[i] = VW'(100 - i);
      tick();
      idle();
      chk("single.early_valid", int'(g_cfg[0].bus.out_valid), 0);
      tick();
      chk_out("single", 1, 1, 90, 10);
      tick();
      chk("single.one_cycle", int'(g_cfg[0].bus.out_valid), 0);

      // Tie at value 5 between nodes 3 and 7.
      in_valid = 1'b1;
      pres_all = '0;
      pres_all[3] = 1'b1;
      pres_all[7] = 1'b1;
      for (int i = 0; i < MAXN; i++) vals_all[i] = VW'(1);
      vals_all[3] = VW'(5);
      vals_all[7] = VW'(5);
      tick();
      idle();
      tick();
      chk_out("tie", 1, 1, 5, 3);

      // None present.
      in_valid = 1'b1;
      for (int i = 0; i < MAXN; i++) vals_all[i] = VW'(7);
      tick();
      idle();
      tick();
      chk_out("none", 1, 0, 0, 0);

      // Streaming: four back-to-back sets.
      for (int k = 0; k < 6; k++) begin
         if (k < 4) set_winner(win[k], 50, 10);
         else idle();
         tick();
         if (k >= 1 && k <= 4) begin
            chk($sformatf("stream%0d.valid", k - 1), int'(g_cfg[0].bus.out_valid), 1);
            chk($sformatf("stream%0d.index", k - 1), int'(g_cfg[0].bus.out_index), win[k-1]);
         end
      end
      chk("stream.end", int'(g_cfg[0].bus.out_valid), 0);

      // Flush: set A at t, clear (with dropped set) at t+1, set B at t+2.
      set_winner(4, 40, 9);
      tick();
      set_winner(6, 40, 2);
      clear = 1'b1;
      chk("flush.t1", int'(g_cfg[0].bus.out_valid), 0);
      tick();
      set_winner(8, 40, 3);
      chk("flush.t2", int'(g_cfg[0].bus.out_valid), 0);
      tick();
      idle();
      chk("flush.t3", int'(g_cfg[0].bus.out_valid), 0);
      tick();
      chk_out("flush.t4", 1, 1, 3, 8);

      // Async reset with two sets in flight.
      set_winner(1, 60, 20);
      tick();
      set_winner(9, 60, 21);
      tick();
      idle();
      chk("areset.pre", int'(g_cfg[0].bus.out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk_out("areset", 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("areset.stale%0d", k), int'(g_cfg[0].bus.out_valid), 0);
      end

      // Random sweep across all configurations.
      for (int c = 0; c < 400; c++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         clear    = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 2))
            0: pres_all = MAXN'($urandom);
            1: pres_all = MAXN'($urandom) & MAXN'($urandom) & MAXN'($urandom);
            default: pres_all = '1;
         endcase
         for (int i = 0; i < MAXN; i++) begin
            if (c % 2 == 0) vals_all[i] = VW'($urandom_range(0, 7));
            else            vals_all[i] = VW'($urandom);
         end
         tick();
      end
      idle();
      repeat (8) tick();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
